pcie_link_channel: RTL and testbench

- Parametrised serial-link channel model that sits between the host and endpoint PcieVhost lane buses in a test harness, replacing direct wire/negedge-register lane hookups.
- Per lane it adds a programmable delay (lane-to-lane skew), optional polarity inversion and one-shot symbol corruption, plus global lane reversal and forced electrical idle.
- It exercises the VHost deskew, polarity and training logic under controlled, repeatable link impairments.
- One instance per direction (downstream, upstream).

---
 rtl/pcie_link_channel.sv | 96 +++++++++
 tb/tb_pcie_link_channel.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_link_channel.sv
// pcie_link_channel: per-lane delay/skew, polarity, one-shot corruption, lane reversal and forced idle between two lane buses
module pcie_link_channel #(
  parameter int NUM_LANES  = 16,
  parameter int MAX_DELAY  = 16,
  parameter int DELAY_BITS = $clog2(MAX_DELAY)
) (
  input  logic                    Clk,
  input  logic                    notReset,
  input  logic [NUM_LANES*10-1:0] LinkIn,
  input  logic [NUM_LANES-1:0]    ElecIdleIn,
  output logic [NUM_LANES*10-1:0] LinkOut,
  output logic [NUM_LANES-1:0]    ElecIdleOut,
  input  logic                    CfgWe,
  input  logic [4:0]              CfgLane,
  input  logic [DELAY_BITS-1:0]   CfgDelay,
  input  logic                    CfgInvert,
  input  logic                    CfgCorrupt,
  input  logic                    Reverse,
  input  logic                    ForceIdle,
  output logic [NUM_LANES-1:0]    Settling
);
  logic [10:0]             mem_q    [NUM_LANES][MAX_DELAY];
  logic [10:0]             mem_d    [NUM_LANES];
  logic [10:0]             tap      [NUM_LANES];
  logic [DELAY_BITS-1:0]   delay_q  [NUM_LANES];
  logic [DELAY_BITS-1:0]   delay_d  [NUM_LANES];
  logic [DELAY_BITS:0]     settle_q [NUM_LANES];
  logic [DELAY_BITS:0]     settle_d [NUM_LANES];
  logic [DELAY_BITS-1:0]   wp_q, wp_d;
  logic [NUM_LANES-1:0]    invert_q, invert_d, pend_q, pend_d, eidle_q, eidle_d;
  logic [NUM_LANES-1:0]    wr, live, flip;
  logic [NUM_LANES*10-1:0] link_q, link_d;
  logic                    rev_q, rev_d;

  assign LinkOut     = link_q;
  assign ElecIdleOut = eidle_q;

  // Per-lane source select, delay tap, config update, settle countdown and output shaping
  always_comb begin
    wp_d     = wp_q + DELAY_BITS'(1);
    rev_d    = Reverse;
    wr       = '0;
    live     = '0;
    flip     = '0;
    invert_d = '0;
    pend_d   = '0;
    eidle_d  = '0;
    link_d   = '0;
    Settling = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mem_d[i]    = Reverse ? {ElecIdleIn[NUM_LANES-1-i], LinkIn[10*(NUM_LANES-1-i) +: 10]}
                            : {ElecIdleIn[i], LinkIn[10*i +: 10]};
      tap[i]      = (delay_q[i] == '0) ? mem_d[i] : mem_q[i][wp_q - delay_q[i]];
      wr[i]       = CfgWe && CfgLane < 5'(NUM_LANES) && CfgLane == 5'(i);
      delay_d[i]  = wr[i] ? CfgDelay : delay_q[i];
      invert_d[i] = wr[i] ? CfgInvert : invert_q[i];
      settle_d[i] = (Reverse != rev_q || (wr[i] && CfgDelay != delay_q[i])) ? {1'b0, delay_d[i]} + (DELAY_BITS+1)'(1)
                  : (settle_q[i] != '0) ? settle_q[i] - (DELAY_BITS+1)'(1) : settle_q[i];
      live[i]     = !ForceIdle && settle_d[i] == '0;
      flip[i]     = live[i] && !tap[i][10] && pend_q[i];
      pend_d[i]   = (pend_q[i] && !flip[i]) || (wr[i] && CfgCorrupt);
      eidle_d[i]  = live[i] ? tap[i][10] : 1'b1;
      link_d[10*i +: 10] = live[i] ? tap[i][9:0] ^ {10{invert_q[i]}} ^ {9'b0, flip[i]} : 10'b0;
      Settling[i] = settle_q[i] != '0;
    end
  end

  // State registers; reset blanks every lane to electrical idle
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      wp_q     <= '0;
      rev_q    <= 1'b0;
      invert_q <= '0;
      pend_q   <= '0;
      eidle_q  <= '1;
      link_q   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        delay_q[i]  <= '0;
        settle_q[i] <= '0;
        for (int j = 0; j < MAX_DELAY; j++) mem_q[i][j] <= '0;
      end
    end else begin
      wp_q     <= wp_d;
      rev_q    <= rev_d;
      invert_q <= invert_d;
      pend_q   <= pend_d;
      eidle_q  <= eidle_d;
      link_q   <= link_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        delay_q[i]        <= delay_d[i];
        settle_q[i]       <= settle_d[i];
        mem_q[i][wp_q]    <= mem_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pcie_link_channel.sv
// tb_pcie_link_channel: vector table, directed corner sequences and random traffic against a history-based model
module tb_pcie_link_channel;
  localparam int L = 4;

  logic          Clk = 1'b0;
  logic          notReset = 1'b1;
  logic [39:0]   link_in = '0;
  logic [3:0]    ei_in = '0;
  logic [39:0]   LinkOut;
  logic [3:0]    ElecIdleOut, Settling;
  logic          cfg_we = 1'b0, cfg_inv = 1'b0, cfg_cor = 1'b0, rev = 1'b0, fi = 1'b0;
  logic [4:0]    cfg_lane = '0;
  logic [3:0]    cfg_delay = '0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  pcie_link_channel #(.NUM_LANES(L), .MAX_DELAY(16)) dut (
    .Clk(Clk), .notReset(notReset), .LinkIn(link_in), .ElecIdleIn(ei_in),
    .LinkOut(LinkOut), .ElecIdleOut(ElecIdleOut),
    .CfgWe(cfg_we), .CfgLane(cfg_lane), .CfgDelay(cfg_delay), .CfgInvert(cfg_inv),
    .CfgCorrupt(cfg_cor), .Reverse(rev), .ForceIdle(fi), .Settling(Settling)
  );

  // Reference model: raw input history per edge, lane config, and blanking deadline per lane
  logic [39:0] h_link [8192];
  logic [3:0]  h_ei   [8192];
  logic        h_rev  [8192];
  int          n;
  int          m_delay [L];
  int          blank_until [L];
  bit          m_inv [L];
  bit          m_pend [L];
  bit          m_rev;
  logic [39:0] e_link;
  logic [3:0]  e_ei, e_set;

  task automatic check(string name, logic [39:0] al, logic [3:0] ae, logic [3:0] as_,
                       logic [39:0] xl, logic [3:0] xe, logic [3:0] xs);
    checks++;
    if ({al, ae, as_} !== {xl, xe, xs}) begin
      errors++;
      $display("FAIL %s: got link=%h idle=%b settling=%b, want link=%h idle=%b settling=%b",
               name, al, ae, as_, xl, xe, xs);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_rev = 1'b0;
    for (int i = 0; i < L; i++) begin
      m_delay[i] = 0;
      blank_until[i] = 0;
      m_inv[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic step(string tag);
    bit tog, hit, blank, fl;
    int m, src;
    logic [10:0] w;
    h_link[n] = link_in;
    h_ei[n]   = ei_in;
    h_rev[n]  = rev;
    tog   = rev != m_rev;
    m_rev = rev;
    hit   = cfg_we && cfg_lane < 5'(L);
    for (int i = 0; i < L; i++) begin
      if (hit && int'(cfg_lane) == i) begin
        if (int'(cfg_delay) != m_delay[i]) blank_until[i] = n + int'(cfg_delay) + 1;
        m_delay[i] = int'(cfg_delay);
      end
      if (tog) blank_until[i] = n + m_delay[i] + 1;
      blank = n < blank_until[i];
      m = n - m_delay[i];
      if (m < 0) w = '0;
      else begin
        src = h_rev[m] ? L - 1 - i : i;
        w = {h_ei[m][src], h_link[m][10*src +: 10]};
      end
      fl = !fi && !blank && !w[10] && m_pend[i];
      e_link[10*i +: 10] = (fi || blank) ? 10'h000 : (w[9:0] ^ {10{m_inv[i]}} ^ {9'b0, fl});
      e_ei[i]  = (fi || blank) ? 1'b1 : w[10];
      e_set[i] = blank;
      if (fl) m_pend[i] = 1'b0;
      if (hit && int'(cfg_lane) == i) begin
        m_inv[i] = cfg_inv;
        if (cfg_cor) m_pend[i] = 1'b1;
      end
    end
    n++;
    @(posedge Clk);
    #1;
    check(tag, LinkOut, ElecIdleOut, Settling, e_link, e_ei, e_set);
  endtask

  task automatic do_reset();
    notReset = 1'b0;
    cfg_we = 1'b0; rev = 1'b0; fi = 1'b0; ei_in = '0;
    #1;
    check("reset_values", LinkOut, ElecIdleOut, Settling, '0, 4'hF, 4'h0);
    @(posedge Clk);
    #1;
    notReset = 1'b1;
    model_reset();
  endtask

  task automatic set_count(int c);
    link_in = {10'h030 + 10'(c), 10'h020 + 10'(c), 10'h010 + 10'(c), 10'(c)};
  endtask

  typedef struct {
    logic [39:0] li;
    logic [3:0]  ei;
    logic        we;
    logic [4:0]  lane;
    logic [3:0]  dly;
    logic        inv, cor, fi;
    logic [39:0] xl;
    logic [3:0]  xe, xs;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [39:0] a, b, c, d;
    int cnt, found;
    a = {10'h3FF, 10'h0AA, 10'h001, 10'h17C};
    b = {10'h3FF, 10'h0AA, 10'h001, 10'h283};
    c = {10'h3FF, 10'h0AA, 10'h001, 10'h282};
    d = {10'h3FF, 10'h000, 10'h001, 10'h283};
    tbl[0]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, a,   4'h0, 4'h0};
    tbl[1]  = '{a, 4'h0, 1, 5'd0,  4'd0, 1, 0, 0, a,   4'h0, 4'h0};
    tbl[2]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[3]  = '{a, 4'h0, 1, 5'd0,  4'd0, 1, 1, 0, b,   4'h0, 4'h0};
    tbl[4]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, c,   4'h0, 4'h0};
    tbl[5]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[6]  = '{a, 4'h0, 1, 5'd20, 4'd3, 1, 1, 0, b,   4'h0, 4'h0};
    tbl[7]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[8]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 1, '0,  4'hF, 4'h0};
    tbl[9]  = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 1, '0,  4'hF, 4'h0};
    tbl[10] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[11] = '{a, 4'h0, 1, 5'd2,  4'd2, 0, 0, 0, d,   4'h4, 4'h4};
    tbl[12] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, d,   4'h4, 4'h4};
    tbl[13] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, d,   4'h4, 4'h4};
    tbl[14] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[15] = '{a, 4'h0, 1, 5'd2,  4'd2, 0, 0, 0, b,   4'h0, 4'h0};
    tbl[16] = '{a, 4'h1, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h1, 4'h0};
    tbl[17] = '{a, 4'h1, 1, 5'd0,  4'd0, 1, 1, 0, b,   4'h1, 4'h0};
    tbl[18] = '{a, 4'h1, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h1, 4'h0};
    tbl[19] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, c,   4'h0, 4'h0};
    tbl[20] = '{a, 4'h0, 0, 5'd0,  4'd0, 0, 0, 0, b,   4'h0, 4'h0};

    #2;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      link_in = tbl[k].li; ei_in = tbl[k].ei; cfg_we = tbl[k].we; cfg_lane = tbl[k].lane;
      cfg_delay = tbl[k].dly; cfg_inv = tbl[k].inv; cfg_cor = tbl[k].cor; fi = tbl[k].fi; rev = 1'b0;
      step("tbl_model");
      check($sformatf("vec%0d", k), LinkOut, ElecIdleOut, Settling, tbl[k].xl, tbl[k].xe, tbl[k].xs);
    end
    cfg_we = 1'b0; fi = 1'b0; ei_in = '0;

    // Lane 3 delay 5: six blanked cycles then a 5-cycle lag against lane 0
    do_reset();
    for (int k = 0; k < 4; k++) begin set_count(k); step("pass_through"); end
    set_count(4); cfg_we = 1'b1; cfg_lane = 5'd3; cfg_delay = 4'd5; cfg_inv = 1'b0; cfg_cor = 1'b0;
    step("delay5_write");
    cfg_we = 1'b0;
    cnt = Settling[3] ? 1 : 0;
    for (int k = 5; k < 14; k++) begin set_count(k); step("delay5_settle"); if (Settling[3]) cnt++; end
    check_int("delay5_settle_cycles", cnt, 6);
    check_int("delay5_lag", int'(LinkOut[39:30] - 10'h030) + 5, int'(LinkOut[9:0]));
    check_int("delay5_lane1_unaffected", int'(LinkOut[19:10]), int'(link_in[19:10]));

    // Reverse 0->1 with zero delays: one settling cycle then lanes swapped
    do_reset();
    for (int k = 0; k < 3; k++) begin set_count(k); step("pre_reverse"); end
    set_count(3); rev = 1'b1; step("reverse_edge");
    check_int("reverse_settling_all", int'(Settling), 15);
    set_count(4); step("reverse_after");
    check_int("reverse_lane0_from_lane3", int'(LinkOut[9:0]), int'(link_in[39:30]));
    check_int("reverse_lane3_from_lane0", int'(LinkOut[39:30]), int'(link_in[9:0]));

    // Delay 15: 16-cycle latency across pointer wrap
    do_reset();
    cfg_we = 1'b1; cfg_lane = 5'd0; cfg_delay = 4'd15; cfg_inv = 1'b0; cfg_cor = 1'b0;
    link_in = '0; step("delay15_write");
    cfg_we = 1'b0;
    for (int k = 0; k < 20; k++) begin link_in[9:0] = 10'(k); step("delay15_settle"); end
    found = -1;
    for (int k = 1; k <= 40 && found < 0; k++) begin
      link_in[9:0] = (k == 1) ? 10'h155 : 10'(k);
      step("delay15_stream");
      if (LinkOut[9:0] == 10'h155) found = k;
    end
    check_int("delay15_latency", found, 16);

    // Pending corruption held by idle input must not survive a mid-stream reset
    do_reset();
    ei_in = 4'b0010; link_in = {$urandom, $urandom};
    cfg_we = 1'b1; cfg_lane = 5'd1; cfg_delay = 4'd0; cfg_inv = 1'b0; cfg_cor = 1'b1;
    step("pend_set");
    cfg_we = 1'b0; cfg_cor = 1'b0;
    step("pend_hold");
    #2;
    do_reset();
    ei_in = '0; link_in = {$urandom, $urandom};
    step("after_reset");
    check_int("no_corrupt_after_reset", int'(LinkOut[19:10]), int'(link_in[19:10]));

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      link_in   = {$urandom, $urandom};
      ei_in     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cfg_we    = $urandom_range(0, 9) == 0;
      cfg_lane  = ($urandom_range(0, 7) == 0) ? 5'd20 : 5'($urandom_range(0, 4));
      cfg_delay = 4'($urandom);
      cfg_inv   = 1'($urandom);
      cfg_cor   = $urandom_range(0, 2) == 0;
      rev       = rev ^ ($urandom_range(0, 49) == 0);
      fi        = $urandom_range(0, 24) == 0;
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
